collision_window: RTL and testbench

COLLISION_WINDOW -- requirements
Module: collision_window

---
 rtl/collision_window.sv | 236 +++++++++++++++++++++++
 tb/tb_collision_window.sv | 472 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_window.sv
// collision_window
//
// Walks a sorted range of entries in memory and emits one XOR record for every
// pair of entries that share a collision key. A sliding window holds the entries
// of the current key group, up to WIN_DEPTH of them. Each new entry whose key
// matches the group is paired with every stored entry, oldest first.
//
// Record layout (DATA_W bits):
//   [DATA_W-1:2*IDX_W]   stored entry ^ new entry (upper field only)
//   [2*IDX_W-1:IDX_W]    index of the stored entry
//   [IDX_W-1:0]          index of the new entry
//
// Ports:
//   eclk, rst                              clock, async active-high reset
//   collision_start                        start pulse, accepted in IDLE only
//   stage_cxor_base / stage_cxor_end       inclusive input address range
//   stage_nxor_base / stage_nxor_limit     output region start / inclusive last
//   memc_cmd_full                          blocks rsend and wvalid while high
//   raddr, rsend, rdata, rvalid            single-outstanding read channel
//   waddr, wdata, wvalid                   record write channel
//   collision_done                         one-cycle completion pulse
//   stage_nxor_end                         first unwritten output address
//   pair_count, overflow_cnt, limit_hit    pass statistics, held until next start
//
// Build option:
//   COLLISION_ZERO_DROP_EN  discard records whose XOR field is all zero.

module collision_window #(
  parameter int DATA_W    = 256,
  parameter int ADDR_W    = 32,
  parameter int KEY_LSB   = 224,
  parameter int KEY_W     = 20,
  parameter int WIN_DEPTH = 8,
  parameter int IDX_W     = 22
) (
  input  logic              eclk,
  input  logic              rst,
  input  logic              collision_start,
  input  logic [ADDR_W-1:0] stage_cxor_base,
  input  logic [ADDR_W-1:0] stage_cxor_end,
  input  logic [ADDR_W-1:0] stage_nxor_base,
  input  logic [ADDR_W-1:0] stage_nxor_limit,
  input  logic              memc_cmd_full,
  output logic [ADDR_W-1:0] raddr,
  output logic              rsend,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rvalid,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              wvalid,
  output logic              collision_done,
  output logic [ADDR_W-1:0] stage_nxor_end,
  output logic [31:0]       pair_count,
  output logic [15:0]       overflow_cnt,
  output logic              limit_hit
);

  localparam int CNT_W = $clog2(WIN_DEPTH + 1);
  localparam int PTR_W = (WIN_DEPTH > 1) ? $clog2(WIN_DEPTH) : 1;
  localparam int XOR_W = DATA_W - 2 * IDX_W;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, DONE} state_t;

  state_t state, next_state;

  logic [ADDR_W-1:0] cxor_base_q, cxor_end_q, nxor_base_q, nxor_limit_q;
  logic [ADDR_W-1:0] cur_addr;
  logic [XOR_W-1:0]  new_data;
  logic [IDX_W-1:0]  new_idx;
  logic [KEY_W-1:0]  win_key;
  logic [CNT_W-1:0]  win_cnt;
  logic [PTR_W-1:0]  emit_ptr;

  // Only the XOR field of each entry is kept; its key lives in win_key.
  logic [XOR_W-1:0]  win_data [WIN_DEPTH];
  logic [IDX_W-1:0]  win_idx  [WIN_DEPTH];

  logic [IDX_W-1:0]  rd_idx;
  logic [KEY_W-1:0]  rd_key;
  logic              key_match;
  logic [XOR_W-1:0]  rec_xor;
  logic              last_rec, last_addr, win_has_room, drop_rec;

  logic start_go, cap_clear, cap_match, rec_step, set_limit, emit_done;

  assign rd_idx       = IDX_W'(cur_addr - cxor_base_q);
  assign rd_key       = rdata[KEY_LSB +: KEY_W];
  assign key_match    = (win_cnt != '0) && (rd_key == win_key);
  assign rec_xor      = win_data[emit_ptr] ^ new_data;
  assign last_rec     = (CNT_W'(emit_ptr) + CNT_W'(1)) == win_cnt;
  assign last_addr    = (cur_addr == cxor_end_q);
  assign win_has_room = (win_cnt < CNT_W'(WIN_DEPTH));
  assign raddr        = cur_addr;
  assign waddr        = nxor_base_q + ADDR_W'(pair_count);

`ifdef COLLISION_ZERO_DROP_EN
  assign drop_rec = (rec_xor == '0);
`else
  assign drop_rec = 1'b0;
`endif

  always_ff @(posedge eclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and handshake decode. In EMIT, once limit_hit is set the
  // remaining records of the pass are skipped but reading carries on so the
  // window and overflow statistics still cover the whole range.
  always_comb begin
    next_state     = state;
    rsend          = 1'b0;
    wvalid         = 1'b0;
    wdata          = '0;
    collision_done = 1'b0;
    start_go       = 1'b0;
    cap_clear      = 1'b0;
    cap_match      = 1'b0;
    rec_step       = 1'b0;
    set_limit      = 1'b0;
    emit_done      = 1'b0;
    case (state)
      IDLE: begin
        if (collision_start) begin
          start_go   = 1'b1;
          next_state = (stage_cxor_end < stage_cxor_base) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (!memc_cmd_full) begin
          rsend      = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (rvalid) begin
          if (key_match) begin
            cap_match  = 1'b1;
            next_state = EMIT;
          end else begin
            cap_clear  = 1'b1;
            next_state = last_addr ? DONE : FETCH;
          end
        end
      end
      EMIT: begin
        if (limit_hit) begin
          emit_done = 1'b1;
        end else if (drop_rec) begin
          rec_step = 1'b1;
        end else if (waddr > nxor_limit_q) begin
          set_limit = 1'b1;
          emit_done = 1'b1;
        end else if (!memc_cmd_full) begin
          wvalid   = 1'b1;
          wdata    = {rec_xor, win_idx[emit_ptr], new_idx};
          rec_step = 1'b1;
        end
        if (rec_step && last_rec) emit_done = 1'b1;
        if (emit_done) next_state = last_addr ? DONE : FETCH;
      end
      DONE: begin
        collision_done = 1'b1;
        next_state     = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Control and statistics registers. A mismatching key restarts the window
  // with the new entry as its only member; a matching entry is appended once
  // its records have all been handled.
  always_ff @(posedge eclk or posedge rst) begin
    if (rst) begin
      cxor_base_q    <= '0;
      cxor_end_q     <= '0;
      nxor_base_q    <= '0;
      nxor_limit_q   <= '0;
      cur_addr       <= '0;
      new_data       <= '0;
      new_idx        <= '0;
      win_key        <= '0;
      win_cnt        <= '0;
      emit_ptr       <= '0;
      pair_count     <= '0;
      overflow_cnt   <= '0;
      limit_hit      <= 1'b0;
      stage_nxor_end <= '0;
    end else begin
      if (start_go) begin
        cxor_base_q  <= stage_cxor_base;
        cxor_end_q   <= stage_cxor_end;
        nxor_base_q  <= stage_nxor_base;
        nxor_limit_q <= stage_nxor_limit;
        cur_addr     <= stage_cxor_base;
        pair_count   <= '0;
        overflow_cnt <= '0;
        limit_hit    <= 1'b0;
        win_cnt      <= '0;
      end
      if (cap_match) begin
        new_data <= rdata[DATA_W-1:2*IDX_W];
        new_idx  <= rd_idx;
        emit_ptr <= '0;
      end
      if (cap_clear) begin
        win_key <= rd_key;
        win_cnt <= CNT_W'(1);
        if (!last_addr) cur_addr <= cur_addr + ADDR_W'(1);
      end
      if (rec_step) begin
        emit_ptr <= emit_ptr + PTR_W'(1);
        if (wvalid) pair_count <= pair_count + 32'd1;
      end
      if (set_limit) limit_hit <= 1'b1;
      if (emit_done) begin
        if (win_has_room)                win_cnt      <= win_cnt + CNT_W'(1);
        else if (overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
        if (!last_addr) cur_addr <= cur_addr + ADDR_W'(1);
      end
      if (state == DONE) stage_nxor_end <= waddr;
    end
  end

  // Window storage needs no reset: win_cnt alone decides which slots are live.
  always_ff @(posedge eclk) begin
    if (cap_clear) begin
      win_data[0] <= rdata[DATA_W-1:2*IDX_W];
      win_idx[0]  <= rd_idx;
    end else if (emit_done && win_has_room) begin
      win_data[win_cnt[PTR_W-1:0]] <= new_data;
      win_idx[win_cnt[PTR_W-1:0]]  <= new_idx;
    end
  end

endmodule

// File: tb/tb_collision_window.sv
// tb_collision_window
//
// Self-checking bench for collision_window. A memory responder serves reads
// with random latency, a monitor captures every accepted write, and a
// behavioural model walks the same memory image to predict the record
// sequence and the pass statistics.

`timescale 1ns/1ps

module tb_collision_window;

  localparam int DATA_W    = 256;
  localparam int ADDR_W    = 32;
  localparam int KEY_LSB   = 224;
  localparam int KEY_W     = 20;
  localparam int WIN_DEPTH = 8;
  localparam int IDX_W     = 22;
  localparam int XOR_W     = DATA_W - 2 * IDX_W;
  localparam int MEM_N     = 64;

`ifdef COLLISION_ZERO_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic              tb_clk = 1'b0;
  logic              rst = 1'b1;
  logic              collision_start = 1'b0;
  logic [ADDR_W-1:0] stage_cxor_base = '0, stage_cxor_end = '0;
  logic [ADDR_W-1:0] stage_nxor_base = '0, stage_nxor_limit = '0;
  logic              memc_cmd_full = 1'b0;
  logic [ADDR_W-1:0] raddr;
  logic              rsend;
  logic [DATA_W-1:0] rdata = '0;
  logic              rvalid = 1'b0;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              wvalid;
  logic              collision_done;
  logic [ADDR_W-1:0] stage_nxor_end;
  logic [31:0]       pair_count;
  logic [15:0]       overflow_cnt;
  logic              limit_hit;

  collision_window #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .KEY_LSB(KEY_LSB), .KEY_W(KEY_W),
    .WIN_DEPTH(WIN_DEPTH), .IDX_W(IDX_W)
  ) dut (
    .eclk(tb_clk), .rst(rst), .collision_start(collision_start),
    .stage_cxor_base(stage_cxor_base), .stage_cxor_end(stage_cxor_end),
    .stage_nxor_base(stage_nxor_base), .stage_nxor_limit(stage_nxor_limit),
    .memc_cmd_full(memc_cmd_full), .raddr(raddr), .rsend(rsend),
    .rdata(rdata), .rvalid(rvalid), .waddr(waddr), .wdata(wdata),
    .wvalid(wvalid), .collision_done(collision_done),
    .stage_nxor_end(stage_nxor_end), .pair_count(pair_count),
    .overflow_cnt(overflow_cnt), .limit_hit(limit_hit)
  );

  always #5 tb_clk = ~tb_clk;

  logic [DATA_W-1:0] mem [MEM_N];
  logic [ADDR_W-1:0] got_addr [$];
  logic [DATA_W-1:0] got_data [$];
  logic [ADDR_W-1:0] exp_addr [$];
  logic [DATA_W-1:0] exp_data [$];
  int unsigned       exp_pc, exp_ovf;
  bit                exp_lim;
  int unsigned       n_cmp = 0, n_fail = 0;
  int unsigned       viol = 0;
  int                full_mode = 0;
  int unsigned       cyc = 0;
  bit                req_pending = 1'b0;
  int                req_addr = 0, req_delay = 0;

  // Monitor: sampled mid-cycle, away from the active edge.
  always @(negedge tb_clk) begin
    if (!rst) begin
      if ((rsend || wvalid) && memc_cmd_full) viol++;
      if (rsend && !memc_cmd_full) begin
        req_pending = 1'b1;
        req_addr    = (raddr < ADDR_W'(MEM_N)) ? int'(raddr) : 0;
        req_delay   = $urandom_range(0, 2);
      end
      if (wvalid && !memc_cmd_full) begin
        got_addr.push_back(waddr);
        got_data.push_back(wdata);
      end
    end
  end

  // Read responder with 0..2 cycles of extra latency.
  initial forever begin
    @(posedge tb_clk); #1;
    rvalid = 1'b0;
    if (rst) req_pending = 1'b0;
    else if (req_pending) begin
      if (req_delay == 0) begin
        rvalid      = 1'b1;
        rdata       = mem[req_addr];
        req_pending = 1'b0;
      end else req_delay--;
    end
  end

  // Backpressure generator: off, 4 of every 64 cycles, or random.
  initial forever begin
    @(posedge tb_clk); #1;
    cyc++;
    case (full_mode)
      0:       memc_cmd_full = 1'b0;
      1:       memc_cmd_full = ((cyc % 64) < 4);
      default: memc_cmd_full = ($urandom_range(0, 3) == 0);
    endcase
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [DATA_W-1:0] make_entry(input logic [KEY_W-1:0] key);
    logic [DATA_W-1:0] d;
    for (int w = 0; w < DATA_W / 32; w++) d[w*32 +: 32] = $urandom;
    d[KEY_LSB +: KEY_W] = key;
    return d;
  endfunction

  // Reference: group consecutive equal keys, pair each newcomer with every
  // remembered member of its group, then remember it if there is room.
  task automatic run_model(input int b, input int e, input longint nb, input longint lim);
    int                 win_q [$];
    logic [KEY_W-1:0]   wkey;
    logic [XOR_W-1:0]   x;
    exp_addr.delete();
    exp_data.delete();
    exp_pc  = 0;
    exp_ovf = 0;
    exp_lim = 1'b0;
    wkey    = '0;
    for (int a = b; a <= e; a++) begin
      if (win_q.size() > 0 && mem[a][KEY_LSB +: KEY_W] == wkey) begin
        foreach (win_q[j]) begin
          x = mem[win_q[j]][DATA_W-1:2*IDX_W] ^ mem[a][DATA_W-1:2*IDX_W];
          if (DROP && x == '0) continue;
          if (exp_lim) continue;
          if (nb + longint'(exp_pc) > lim) begin
            exp_lim = 1'b1;
            continue;
          end
          exp_addr.push_back(ADDR_W'(nb + longint'(exp_pc)));
          exp_data.push_back({x, IDX_W'(win_q[j] - b), IDX_W'(a - b)});
          exp_pc++;
        end
      end else begin
        win_q.delete();
      end
      wkey = mem[a][KEY_LSB +: KEY_W];
      if (win_q.size() < WIN_DEPTH) win_q.push_back(a);
      else if (exp_ovf < 65535) exp_ovf++;
    end
  endtask

  function automatic int seq_diff();
    int n;
    n = (exp_addr.size() < got_addr.size()) ? exp_addr.size() : got_addr.size();
    for (int i = 0; i < n; i++)
      if (exp_addr[i] !== got_addr[i] || exp_data[i] !== got_data[i]) return i;
    if (exp_addr.size() != got_addr.size()) return n;
    return -1;
  endfunction

  task automatic tick();
    @(posedge tb_clk); #1;
  endtask

  task automatic start_pass(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] e,
                            input logic [ADDR_W-1:0] nb, input logic [ADDR_W-1:0] lim);
    stage_cxor_base  = b;
    stage_cxor_end   = e;
    stage_nxor_base  = nb;
    stage_nxor_limit = lim;
    got_addr.delete();
    got_data.delete();
    tick();
    collision_start = 1'b1;
    tick();
    collision_start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge tb_clk);
      if (collision_done) begin
        seen = 1'b1;
        break;
      end
    end
    @(negedge tb_clk);
  endtask

  task automatic fill_basic();
    for (int i = 0; i < 16; i++) mem[i] = make_entry(KEY_W'(i / 3));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge tb_clk);
    n_cmp++;
    if ({rsend, wvalid, collision_done, limit_hit} !== 4'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: got %b want 0000", {rsend, wvalid, collision_done, limit_hit});
    end
    n_cmp++;
    if ((raddr | waddr | stage_nxor_end) !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_addr: got raddr %h waddr %h end %h want 0", raddr, waddr, stage_nxor_end);
    end
    n_cmp++;
    if (pair_count !== 32'd0 || overflow_cnt !== 16'd0 || wdata !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_counts: got pairs %0d ovf %0d want 0", pair_count, overflow_cnt);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit seen;
    int d;
    fill_basic();
    full_mode = 0;
    run_model(0, 15, 'h10, 'h20);
    start_pass(0, 15, 'h10, 'h20);
    wait_done(4000, seen);
    n_cmp++;
    if (seen !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_done: got %0d want 1", seen); end
    d = seq_diff();
    n_cmp++;
    if (d != -1) begin
      n_fail++;
      $display("[TB] FAIL basic_writes: first bad write %0d, got %0d writes want %0d", d, got_addr.size(), exp_addr.size());
    end
    n_cmp++;
    if (pair_count !== 32'd15) begin n_fail++; $display("[TB] FAIL basic_pairs: got %0d want 15", pair_count); end
    n_cmp++;
    if (stage_nxor_end !== 32'h1F) begin n_fail++; $display("[TB] FAIL basic_end: got %h want 1f", stage_nxor_end); end
    n_cmp++;
    if (overflow_cnt !== 16'd0 || limit_hit !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL basic_flags: got ovf %0d lim %0d want 0 0", overflow_cnt, limit_hit);
    end
  endtask

  task automatic test_limit();
    bit seen;
    int d;
    run_model(0, 15, 'h10, 'h14);
    start_pass(0, 15, 'h10, 'h14);
    wait_done(4000, seen);
    n_cmp++;
    if (seen !== 1'b1) begin n_fail++; $display("[TB] FAIL limit_done: got %0d want 1", seen); end
    d = seq_diff();
    n_cmp++;
    if (d != -1 || got_addr.size() != 5) begin
      n_fail++;
      $display("[TB] FAIL limit_writes: first bad %0d, got %0d writes want 5", d, got_addr.size());
    end
    n_cmp++;
    if (pair_count !== 32'd5 || limit_hit !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL limit_stats: got pairs %0d lim %0d want 5 1", pair_count, limit_hit);
    end
    n_cmp++;
    if (stage_nxor_end !== 32'h15) begin n_fail++; $display("[TB] FAIL limit_end: got %h want 15", stage_nxor_end); end
  endtask

  task automatic test_backpressure();
    bit seen;
    int d;
    viol = 0;
    full_mode = 1;
    run_model(0, 15, 'h10, 'h20);
    start_pass(0, 15, 'h10, 'h20);
    repeat (20) tick();
    // A start while busy must not disturb the pass in flight.
    stage_cxor_base  = 'h3;
    stage_nxor_base  = 'h40;
    stage_nxor_limit = 'h41;
    collision_start  = 1'b1;
    tick();
    collision_start  = 1'b0;
    wait_done(4000, seen);
    full_mode = 0;
    n_cmp++;
    if (seen !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_done: got %0d want 1", seen); end
    n_cmp++;
    if (viol != 0) begin n_fail++; $display("[TB] FAIL bp_handshake: got %0d requests under full want 0", viol); end
    d = seq_diff();
    n_cmp++;
    if (d != -1) begin
      n_fail++;
      $display("[TB] FAIL bp_writes: first bad write %0d, got %0d writes want %0d", d, got_addr.size(), exp_addr.size());
    end
    n_cmp++;
    if (pair_count !== 32'd15 || stage_nxor_end !== 32'h1F) begin
      n_fail++;
      $display("[TB] FAIL bp_stats: got pairs %0d end %h want 15 1f", pair_count, stage_nxor_end);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bit hit;
    int d;
    hit = 1'b0;
    start_pass(0, 15, 'h10, 'h20);
    for (int i = 0; i < 2000; i++) begin
      @(negedge tb_clk);
      if (wvalid && got_addr.size() >= 3) begin
        hit = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (hit !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_reach_emit: got %0d want 1", hit); end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({rsend, wvalid, collision_done, limit_hit} !== 4'b0 || wdata !== '0) begin
      n_fail++;
      $display("[TB] FAIL midrst_ctrl: got %b want 0000", {rsend, wvalid, collision_done, limit_hit});
    end
    n_cmp++;
    if ((raddr | waddr | stage_nxor_end) !== '0 || pair_count !== 32'd0 || overflow_cnt !== 16'd0) begin
      n_fail++;
      $display("[TB] FAIL midrst_regs: got raddr %h waddr %h pairs %0d want 0", raddr, waddr, pair_count);
    end
    repeat (2) tick();
    rst = 1'b0;
    tick();
    run_model(0, 15, 'h10, 'h20);
    start_pass(0, 15, 'h10, 'h20);
    wait_done(4000, seen);
    d = seq_diff();
    n_cmp++;
    if (seen !== 1'b1 || d != -1) begin
      n_fail++;
      $display("[TB] FAIL midrst_rerun_writes: done %0d first bad %0d, want 1 -1", seen, d);
    end
    n_cmp++;
    if (pair_count !== 32'd15 || stage_nxor_end !== 32'h1F) begin
      n_fail++;
      $display("[TB] FAIL midrst_rerun_stats: got pairs %0d end %h want 15 1f", pair_count, stage_nxor_end);
    end
  endtask

  task automatic test_overflow();
    bit seen;
    int d;
    for (int i = 0; i < 10; i++) mem[32 + i] = make_entry(KEY_W'(7));
    run_model(32, 41, 'h100, 'h1FF);
    start_pass(32, 41, 'h100, 'h1FF);
    wait_done(4000, seen);
    d = seq_diff();
    n_cmp++;
    if (seen !== 1'b1 || d != -1) begin
      n_fail++;
      $display("[TB] FAIL ovf_writes: done %0d first bad %0d, want 1 -1", seen, d);
    end
    n_cmp++;
    if (pair_count !== 32'd44) begin n_fail++; $display("[TB] FAIL ovf_pairs: got %0d want 44", pair_count); end
    n_cmp++;
    if (overflow_cnt !== 16'd2) begin n_fail++; $display("[TB] FAIL ovf_count: got %0d want 2", overflow_cnt); end
  endtask

  task automatic test_identical();
    bit seen;
    logic [31:0] want_pc;
    mem[48] = make_entry(KEY_W'(3));
    mem[49] = mem[48];
    want_pc = DROP ? 32'd0 : 32'd1;
    start_pass(48, 49, 'h200, 'h2FF);
    wait_done(4000, seen);
    n_cmp++;
    if (seen !== 1'b1 || pair_count !== want_pc) begin
      n_fail++;
      $display("[TB] FAIL ident_pairs: done %0d got %0d want %0d", seen, pair_count, want_pc);
    end
    n_cmp++;
    if (got_addr.size() != int'(want_pc)) begin
      n_fail++;
      $display("[TB] FAIL ident_writes: got %0d writes want %0d", got_addr.size(), want_pc);
    end
    start_pass(5, 4, 'h300, 'h3FF);
    wait_done(50, seen);
    n_cmp++;
    if (seen !== 1'b1 || got_addr.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL empty_done: done %0d writes %0d want 1 0", seen, got_addr.size());
    end
    n_cmp++;
    if (pair_count !== 32'd0 || overflow_cnt !== 16'd0 || stage_nxor_end !== 32'h300) begin
      n_fail++;
      $display("[TB] FAIL empty_stats: got pairs %0d ovf %0d end %h want 0 0 300", pair_count, overflow_cnt, stage_nxor_end);
    end
  endtask

  task automatic test_random();
    bit seen;
    int d, b, e;
    logic [KEY_W-1:0] key;
    logic [ADDR_W-1:0] nb, lim;
    for (int it = 0; it < 6; it++) begin
      b   = $urandom_range(16, 24);
      e   = b + $urandom_range(0, 23);
      key = KEY_W'($urandom_range(0, 3));
      for (int a = b; a <= e; a++) begin
        if ($urandom_range(0, 2) == 0) key = KEY_W'($urandom_range(0, 3));
        if (a > b && $urandom_range(0, 5) == 0) mem[a] = mem[a - 1];
        else mem[a] = make_entry(key);
      end
      nb  = ADDR_W'($urandom_range(256, 512));
      lim = nb + ADDR_W'($urandom_range(0, 40));
      full_mode = $urandom_range(0, 2);
      viol = 0;
      run_model(b, e, longint'(nb), longint'(lim));
      start_pass(ADDR_W'(b), ADDR_W'(e), nb, lim);
      wait_done(20000, seen);
      full_mode = 0;
      d = seq_diff();
      n_cmp++;
      if (seen !== 1'b1 || d != -1) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_writes: done %0d first bad %0d, got %0d writes want %0d", it, seen, d, got_addr.size(), exp_addr.size());
      end
      n_cmp++;
      if (pair_count !== exp_pc) begin n_fail++; $display("[TB] FAIL rand%0d_pairs: got %0d want %0d", it, pair_count, exp_pc); end
      n_cmp++;
      if (overflow_cnt !== 16'(exp_ovf) || limit_hit !== exp_lim) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_flags: got ovf %0d lim %0d want %0d %0d", it, overflow_cnt, limit_hit, exp_ovf, exp_lim);
      end
      n_cmp++;
      if (stage_nxor_end !== nb + exp_pc) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_end: got %h want %h", it, stage_nxor_end, nb + exp_pc);
      end
      n_cmp++;
      if (viol != 0) begin n_fail++; $display("[TB] FAIL rand%0d_handshake: got %0d want 0", it, viol); end
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_N; i++) mem[i] = '0;
    test_reset();
    test_basic();
    test_limit();
    test_backpressure();
    test_reset_mid();
    test_overflow();
    test_identical();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
